// File: rtl/main_host_seq_pkg.sv
// Shared definitions for the host-side sequencer of `main`: command codes,
// the byte-order helper and the sequencer state encoding.
package main_host_seq_pkg;

    localparam int MainCMD_SIZE = 4;

    localparam logic [MainCMD_SIZE-1:0] MainCMD_NOP        = 4'h0;
    localparam logic [MainCMD_SIZE-1:0] MainCMD_SETUP_TEST = 4'h1;
    localparam logic [MainCMD_SIZE-1:0] MainCMD_KEYGEN     = 4'h2;
    localparam logic [MainCMD_SIZE-1:0] MainCMD_ENCAPS     = 4'h3;
    localparam logic [MainCMD_SIZE-1:0] MainCMD_DECAPS     = 4'h4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_IN   = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } host_state_e;

    // Byte 0 of the result is byte 7 of the argument, and so on.
    function automatic logic [63:0] swapBytes64(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = w[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/main_host_seq_skid2.sv
// Generic 2-entry valid/ready skid buffer. Ready depends only on occupancy,
// so it never depends combinationally on the downstream ready.
module stream_skid2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = rd_ptr ? slot1 : slot0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0  <= '0;
            slot1  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) slot1 <= in_data;
                else        slot0 <= in_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/main_host_seq.sv
// Host-side initiator for `main`: one command, nIn words in, nOut words out,
// with byte-order conversion on both stream directions.
//
// state   | meaning
// IDLE    | waiting for a start request
// CMD     | offering the latched command to `main`
// IN      | passing upstream words straight into `main`
// OUT     | draining `main` through the skid buffer to the sink
// DONE    | one-cycle completion pulse
module main_host_seq
    import main_host_seq_pkg::*;
#(
    parameter int CMD_SIZE = MainCMD_SIZE,
    parameter int WORD_W   = 64,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CMD_SIZE-1:0] start_cmd,
    input  logic [CNT_W-1:0]    start_nIn,
    input  logic [CNT_W-1:0]    start_nOut,
    input  logic                start_isReady,
    output logic                start_canReceive,
    input  logic [WORD_W-1:0]   src_data,
    input  logic                src_isReady,
    output logic                src_canReceive,
    output logic [WORD_W-1:0]   snk_data,
    output logic                snk_isReady,
    input  logic                snk_canReceive,
    output logic [CMD_SIZE-1:0] main_cmd,
    output logic                main_cmd_isReady,
    input  logic                main_cmd_canReceive,
    output logic [WORD_W-1:0]   main_in,
    output logic                main_in_isReady,
    input  logic                main_in_canReceive,
    input  logic [WORD_W-1:0]   main_out,
    input  logic                main_out_isReady,
    output logic                main_out_canReceive,
    output logic                busy,
    output logic                done
);

    host_state_e         state;
    host_state_e         state_nx;
    logic [CMD_SIZE-1:0] cmd_q;
    logic [CNT_W-1:0]    in_left;
    logic [CNT_W-1:0]    rd_left;
    logic [CNT_W-1:0]    wr_left;

    logic                start_xfer;
    logic                in_xfer;
    logic                mo_push;
    logic                snk_xfer;
    logic                skid_in_valid;
    logic                skid_in_ready;
    logic [WORD_W-1:0]   skid_out_data;
    logic                skid_out_valid;
    logic                skid_out_ready;
    logic                out_phase;

    assign out_phase      = (state == ST_OUT);
    assign start_xfer     = (state == ST_IDLE) && start_isReady;
    assign in_xfer        = (state == ST_IN) && src_isReady && main_in_canReceive;

    // Never accept more words from `main` than the run asked for.
    assign main_out_canReceive = out_phase && (rd_left != '0) && skid_in_ready;
    assign skid_in_valid       = out_phase && (rd_left != '0) && main_out_isReady;
    assign mo_push             = main_out_isReady && main_out_canReceive;

    assign snk_isReady    = out_phase && skid_out_valid;
    assign snk_data       = snk_isReady ? swapBytes64(skid_out_data) : '0;
    assign skid_out_ready = out_phase && snk_canReceive;
    assign snk_xfer       = snk_isReady && snk_canReceive;

    stream_skid2 #(
        .W (WORD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (main_out),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out_data),
        .out_valid (skid_out_valid),
        .out_ready (skid_out_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        start_canReceive = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;
        main_cmd         = '0;
        main_cmd_isReady = 1'b0;
        main_in          = '0;
        main_in_isReady  = 1'b0;
        src_canReceive   = 1'b0;
        case (state)
            ST_IDLE: begin
                start_canReceive = 1'b1;
                busy             = 1'b0;
                if (start_isReady) state_nx = ST_CMD;
            end
            ST_CMD: begin
                main_cmd         = cmd_q;
                main_cmd_isReady = 1'b1;
                if (main_cmd_canReceive) begin
                    if (in_left != '0)      state_nx = ST_IN;
                    else if (rd_left != '0) state_nx = ST_OUT;
                    else                    state_nx = ST_DONE;
                end
            end
            ST_IN: begin
                main_in         = swapBytes64(src_data);
                main_in_isReady = src_isReady;
                src_canReceive  = main_in_canReceive;
                if (in_xfer && (in_left == CNT_W'(1))) begin
                    state_nx = (rd_left != '0) ? ST_OUT : ST_DONE;
                end
            end
            ST_OUT: begin
                // The last delivery empties the skid, since rd_left is already 0.
                if (snk_xfer && (wr_left == CNT_W'(1))) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q   <= '0;
            in_left <= '0;
            rd_left <= '0;
            wr_left <= '0;
        end else begin
            if (start_xfer) begin
                cmd_q   <= start_cmd;
                in_left <= start_nIn;
                rd_left <= start_nOut;
                wr_left <= start_nOut;
            end
            if (in_xfer)  in_left <= in_left - CNT_W'(1);
            if (mo_push)  rd_left <= rd_left - CNT_W'(1);
            if (snk_xfer) wr_left <= wr_left - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_main_host_seq.sv
// Self-checking bench for main_host_seq: directed scenarios plus randomized
// runs compared against a queue-based model of the expected word streams.
module tb_main_host_seq;
    import main_host_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  start_cmd;
    logic [15:0] start_nIn;
    logic [15:0] start_nOut;
    logic        start_isReady;
    logic        start_canReceive;
    logic [63:0] src_data;
    logic        src_isReady;
    logic        src_canReceive;
    logic [63:0] snk_data;
    logic        snk_isReady;
    logic        snk_canReceive;
    logic [3:0]  main_cmd;
    logic        main_cmd_isReady;
    logic        main_cmd_canReceive;
    logic [63:0] main_in;
    logic        main_in_isReady;
    logic        main_in_canReceive;
    logic [63:0] main_out;
    logic        main_out_isReady;
    logic        main_out_canReceive;
    logic        busy;
    logic        done;

    main_host_seq dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_cmd           (start_cmd),
        .start_nIn           (start_nIn),
        .start_nOut          (start_nOut),
        .start_isReady       (start_isReady),
        .start_canReceive    (start_canReceive),
        .src_data            (src_data),
        .src_isReady         (src_isReady),
        .src_canReceive      (src_canReceive),
        .snk_data            (snk_data),
        .snk_isReady         (snk_isReady),
        .snk_canReceive      (snk_canReceive),
        .main_cmd            (main_cmd),
        .main_cmd_isReady    (main_cmd_isReady),
        .main_cmd_canReceive (main_cmd_canReceive),
        .main_in             (main_in),
        .main_in_isReady     (main_in_isReady),
        .main_in_canReceive  (main_in_canReceive),
        .main_out            (main_out),
        .main_out_isReady    (main_out_isReady),
        .main_out_canReceive (main_out_canReceive),
        .busy                (busy),
        .done                (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] src_words[$];
    logic [63:0] mo_words[$];
    logic [63:0] got_in[$];
    logic [63:0] got_out[$];
    int          mo_cyc[$];
    int          snk_cyc[$];
    int          src_idx, mo_idx, cmd_xfers, cmd_cyc, last_in_cyc;
    int          done_cyc, done_cnt, block_acc;
    logic [3:0]  got_cmd;
    logic        post_busy, post_scr;
    bit          timed_out;

    localparam logic [139:0] RESET_OUTS = {1'b1, 139'd0};

    function automatic logic [63:0] ref_swap(input logic [63:0] w);
        return {<<8{w}};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [139:0] all_outs();
        return {start_canReceive, src_canReceive, snk_data, snk_isReady, main_cmd,
                main_cmd_isReady, main_in, main_in_isReady, main_out_canReceive, busy, done};
    endfunction

    task automatic idle_inputs();
        start_cmd = '0; start_nIn = '0; start_nOut = '0; start_isReady = 1'b0;
        src_data = '0; src_isReady = 1'b0; snk_canReceive = 1'b0;
        main_cmd_canReceive = 1'b0; main_in_canReceive = 1'b0;
        main_out = '0; main_out_isReady = 1'b0;
    endtask

    // Drives one run cycle by cycle and records what crossed each interface.
    task automatic run_job(input logic [3:0] cmd, input int n_in, input int n_out,
                           input int p_src, input int p_min, input int p_mout, input int p_snk,
                           input int p_cmd, input int snk_hold, input int abort_in, input int max_cyc);
        int cyc;
        bit started, src_v, mo_v;
        got_in.delete(); got_out.delete(); mo_cyc.delete(); snk_cyc.delete();
        src_idx = 0; mo_idx = 0; cmd_xfers = 0; cmd_cyc = -1; last_in_cyc = -1;
        done_cyc = -1; done_cnt = 0; block_acc = -1; got_cmd = '0;
        post_busy = 1'bx; post_scr = 1'bx; timed_out = 0;
        cyc = 0; started = 0; src_v = 0; mo_v = 0;
        while (1) begin
            @(negedge clk);
            start_isReady = !started;
            start_cmd = cmd; start_nIn = 16'(n_in); start_nOut = 16'(n_out);
            main_cmd_canReceive = ($urandom_range(99) < p_cmd);
            if (!src_v && src_idx < n_in) src_v = ($urandom_range(99) < p_src);
            src_isReady = src_v;
            src_data = src_v ? src_words[src_idx] : '0;
            main_in_canReceive = ($urandom_range(99) < p_min);
            if (!mo_v && mo_idx < mo_words.size()) mo_v = ($urandom_range(99) < p_mout);
            main_out_isReady = mo_v;
            main_out = mo_v ? mo_words[mo_idx] : '0;
            snk_canReceive = (cyc >= snk_hold) && ($urandom_range(99) < p_snk);
            #1;
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                post_busy = busy; post_scr = start_canReceive;
                break;
            end
            if (start_isReady && start_canReceive) started = 1;
            if (main_cmd_isReady && main_cmd_canReceive) begin
                cmd_xfers++; cmd_cyc = cyc; got_cmd = main_cmd;
            end
            if (main_in_isReady && main_in_canReceive) begin
                got_in.push_back(main_in); last_in_cyc = cyc;
            end
            if (src_isReady && src_canReceive) begin
                src_idx++; src_v = 0;
            end
            if (main_out_isReady && main_out_canReceive) begin
                mo_idx++; mo_v = 0; mo_cyc.push_back(cyc);
            end else if (main_out_isReady && busy && block_acc < 0 && mo_idx < n_out && mo_cyc.size() > 0) begin
                block_acc = mo_idx;
            end
            if (snk_isReady && snk_canReceive) begin
                got_out.push_back(snk_data); snk_cyc.push_back(cyc);
            end
            if (done) begin
                done_cyc = cyc; done_cnt++;
            end
            if (abort_in >= 0 && got_in.size() >= abort_in) break;
            if (cyc >= max_cyc) begin
                timed_out = 1; break;
            end
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        src_isReady = 1'b1; main_out_isReady = 1'b1; main_in_canReceive = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_outs() !== RESET_OUTS) begin
            errors++; $display("FAIL reset_outputs got=%h exp=%h", all_outs(), RESET_OUTS);
        end
        rst = 1'b0;
        idle_inputs();
        @(negedge clk); #1;
        checks++;
        if (all_outs() !== RESET_OUTS) begin
            errors++; $display("FAIL post_reset_idle got=%h exp=%h", all_outs(), RESET_OUTS);
        end
    endtask

    task automatic test_swap();
        src_words = '{64'h0011223344556677};
        mo_words  = '{64'h7766554433221100};
        run_job(MainCMD_ENCAPS, 1, 1, 100, 100, 100, 100, 100, 0, -1, 50);
        idle_inputs();
        checks++;
        if (timed_out || got_in.size() != 1 || got_out.size() != 1) begin
            errors++; $display("FAIL swap_run in=%0d out=%0d exp 1/1 timeout=%0d", got_in.size(), got_out.size(), timed_out);
        end else begin
            checks++;
            if (got_in[0] !== 64'h7766554433221100) begin
                errors++; $display("FAIL swap_main_in got=%h exp=7766554433221100", got_in[0]);
            end
            checks++;
            if (got_out[0] !== 64'h0011223344556677) begin
                errors++; $display("FAIL swap_snk got=%h exp=0011223344556677", got_out[0]);
            end
            checks++;
            if (got_cmd !== MainCMD_ENCAPS) begin
                errors++; $display("FAIL swap_cmd got=%h exp=%h", got_cmd, MainCMD_ENCAPS);
            end
        end
    endtask

    task automatic test_throughput();
        mo_words.delete();
        for (int i = 0; i < 4; i++) mo_words.push_back(rnd64());
        run_job(MainCMD_DECAPS, 0, 4, 100, 100, 100, 100, 100, 0, -1, 50);
        idle_inputs();
        checks++;
        if (timed_out || snk_cyc.size() != 4 || mo_cyc.size() != 4) begin
            errors++; $display("FAIL thr_count snk=%0d mo=%0d exp 4 timeout=%0d", snk_cyc.size(), mo_cyc.size(), timed_out);
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (snk_cyc[i] != snk_cyc[0] + i) begin
                    errors++; $display("FAIL thr_consecutive idx=%0d got=%0d exp=%0d", i, snk_cyc[i], snk_cyc[0] + i);
                end
            end
            checks++;
            if (snk_cyc[0] != mo_cyc[0] + 1) begin
                errors++; $display("FAIL thr_latency got=%0d exp=%0d", snk_cyc[0], mo_cyc[0] + 1);
            end
            checks++;
            if (done_cyc != snk_cyc[3] + 1) begin
                errors++; $display("FAIL thr_done got=%0d exp=%0d", done_cyc, snk_cyc[3] + 1);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_out[i] !== ref_swap(mo_words[i])) begin
                    errors++; $display("FAIL thr_data idx=%0d got=%h exp=%h", i, got_out[i], ref_swap(mo_words[i]));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        mo_words.delete();
        for (int i = 0; i < 4; i++) mo_words.push_back(rnd64());
        run_job(MainCMD_KEYGEN, 0, 4, 100, 100, 100, 100, 100, 5, -1, 60);
        idle_inputs();
        checks++;
        if (block_acc != 2) begin
            errors++; $display("FAIL bp_block_after got=%0d exp=2", block_acc);
        end
        checks++;
        if (timed_out || got_out.size() != 4 || mo_idx != 4) begin
            errors++; $display("FAIL bp_count out=%0d mo=%0d exp 4 timeout=%0d", got_out.size(), mo_idx, timed_out);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_out[i] !== ref_swap(mo_words[i])) begin
                    errors++; $display("FAIL bp_data idx=%0d got=%h exp=%h", i, got_out[i], ref_swap(mo_words[i]));
                end
            end
        end
    endtask

    task automatic test_exact_count();
        mo_words.delete();
        for (int i = 0; i < 7; i++) mo_words.push_back(rnd64());
        run_job(MainCMD_DECAPS, 0, 3, 100, 100, 100, 100, 100, 0, -1, 50);
        checks++;
        if (timed_out || mo_idx != 3) begin
            errors++; $display("FAIL exact_mo_xfers got=%0d exp=3 timeout=%0d", mo_idx, timed_out);
        end
        main_out_isReady = 1'b1;
        main_out = mo_words[3];
        snk_canReceive = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (main_out_canReceive !== 1'b0) begin
                errors++; $display("FAIL exact_no_overread cyc=%0d got=%b exp=0", i, main_out_canReceive);
            end
        end
        idle_inputs();
    endtask

    task automatic test_zero_length();
        mo_words = '{rnd64(), rnd64()};
        run_job(MainCMD_NOP, 0, 0, 100, 100, 100, 100, 100, 0, -1, 30);
        idle_inputs();
        checks++;
        if (timed_out || cmd_xfers != 1 || done_cyc != cmd_cyc + 1) begin
            errors++; $display("FAIL zero_done cmd_cyc=%0d done_cyc=%0d cmds=%0d timeout=%0d", cmd_cyc, done_cyc, cmd_xfers, timed_out);
        end
        checks++;
        if (got_in.size() + got_out.size() + mo_idx + src_idx != 0) begin
            errors++; $display("FAIL zero_activity in=%0d out=%0d mo=%0d src=%0d exp 0", got_in.size(), got_out.size(), mo_idx, src_idx);
        end
        checks++;
        if (post_busy !== 1'b0 || post_scr !== 1'b1) begin
            errors++; $display("FAIL zero_idle busy=%b scr=%b exp 0/1", post_busy, post_scr);
        end
    endtask

    task automatic test_reset_mid_in();
        src_words.delete();
        for (int i = 0; i < 22; i++) src_words.push_back(rnd64());
        mo_words.delete();
        run_job(MainCMD_SETUP_TEST, 22, 0, 100, 100, 100, 100, 100, 0, 5, 60);
        @(posedge clk); #2;
        checks++;
        if (busy !== 1'b1 || main_in_isReady !== 1'b1) begin
            errors++; $display("FAIL rst_mid_active busy=%b main_in_isReady=%b exp 1/1", busy, main_in_isReady);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== RESET_OUTS) begin
            errors++; $display("FAIL rst_mid_outputs got=%h exp=%h", all_outs(), RESET_OUTS);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        src_words.delete();
        for (int i = 0; i < 22; i++) src_words.push_back(rnd64());
        run_job(MainCMD_SETUP_TEST, 22, 0, 100, 100, 100, 100, 100, 0, -1, 100);
        idle_inputs();
        checks++;
        if (timed_out || got_in.size() != 22 || done_cnt != 1) begin
            errors++; $display("FAIL rst_rerun_count got=%0d exp=22 done=%0d timeout=%0d", got_in.size(), done_cnt, timed_out);
        end else begin
            for (int i = 0; i < 22; i++) begin
                checks++;
                if (got_in[i] !== ref_swap(src_words[i])) begin
                    errors++; $display("FAIL rst_rerun_data idx=%0d got=%h exp=%h", i, got_in[i], ref_swap(src_words[i]));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 20; j++) begin
            int n_in, n_out, budget;
            logic [3:0] cmd;
            n_in  = $urandom_range(12);
            n_out = $urandom_range(12);
            cmd   = 4'($urandom_range(15));
            src_words.delete();
            mo_words.delete();
            for (int i = 0; i < n_in; i++) src_words.push_back(rnd64());
            for (int i = 0; i < n_out + 2; i++) mo_words.push_back(rnd64());
            budget = 200 + 30 * (n_in + n_out);
            run_job(cmd, n_in, n_out, $urandom_range(40, 100), $urandom_range(40, 100),
                    $urandom_range(40, 100), $urandom_range(40, 100), $urandom_range(40, 100), 0, -1, budget);
            idle_inputs();
            checks++;
            if (timed_out || done_cnt != 1 || cmd_xfers != 1 || got_cmd !== cmd) begin
                errors++; $display("FAIL rnd_run job=%0d timeout=%0d done=%0d cmds=%0d cmd=%h exp=%h", j, timed_out, done_cnt, cmd_xfers, got_cmd, cmd);
            end
            checks++;
            if (got_in.size() != n_in || got_out.size() != n_out || mo_idx != n_out) begin
                errors++; $display("FAIL rnd_counts job=%0d in=%0d/%0d out=%0d/%0d mo=%0d", j, got_in.size(), n_in, got_out.size(), n_out, mo_idx);
            end
            for (int i = 0; i < n_in && i < got_in.size(); i++) begin
                checks++;
                if (got_in[i] !== ref_swap(src_words[i])) begin
                    errors++; $display("FAIL rnd_in job=%0d idx=%0d got=%h exp=%h", j, i, got_in[i], ref_swap(src_words[i]));
                end
            end
            for (int i = 0; i < n_out && i < got_out.size(); i++) begin
                checks++;
                if (got_out[i] !== ref_swap(mo_words[i])) begin
                    errors++; $display("FAIL rnd_out job=%0d idx=%0d got=%h exp=%h", j, i, got_out[i], ref_swap(mo_words[i]));
                end
            end
            if (n_in > 0 && mo_cyc.size() > 0) begin
                checks++;
                if (mo_cyc[0] <= last_in_cyc) begin
                    errors++; $display("FAIL rnd_phase_order job=%0d first_out=%0d last_in=%0d", j, mo_cyc[0], last_in_cyc);
                end
            end
            checks++;
            if (!timed_out && (post_busy !== 1'b0 || post_scr !== 1'b1)) begin
                errors++; $display("FAIL rnd_idle job=%0d busy=%b scr=%b exp 0/1", j, post_busy, post_scr);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_swap();
        test_throughput();
        test_backpressure();
        test_exact_count();
        test_zero_length();
        test_reset_mid_in();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_host_seq.md
Name: main_host_seq

Overview:
- Host-side initiator for `main`. It issues one command, streams a fixed number of input words into `main`, then drains a fixed number of result words out of it.
- Byte order is converted in both directions with a swapBytes64 function. Upstream and downstream therefore use natural big-endian vector order, and `main` sees its native word order.
- Sits between a host FIFO/DMA and `main`, in place of a software bench driver.

Parameters:
- CMD_SIZE, 4, width of the `main` command word; must equal MainCMD_SIZE.
- WORD_W, 64, stream word width; fixed at 64.
- CNT_W, 16, word-counter width; covers the largest decaps input of about 8200 words.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start_cmd  in  CMD_SIZE  command to issue
- start_nIn  in  CNT_W  number of words to send to `main`
- start_nOut  in  CNT_W  number of words to receive from `main`
- start_isReady  in  1  start request valid
- start_canReceive  out  1  high only in IDLE
- src_data  in  64  upstream word, big-endian
- src_isReady  in  1  upstream word valid
- src_canReceive  out  1  upstream word accepted
- snk_data  out  64  downstream word, big-endian
- snk_isReady  out  1  downstream word valid
- snk_canReceive  in  1  downstream ready
- main_cmd  out  CMD_SIZE  command to `main`
- main_cmd_isReady  out  1  command valid
- main_cmd_canReceive  in  1  `main` ready for a command
- main_in  out  64  word to `main`
- main_in_isReady  out  1  word valid
- main_in_canReceive  in  1  `main` ready for a word
- main_out  in  64  word from `main`
- main_out_isReady  in  1  `main` word valid
- main_out_canReceive  out  1  ready for a `main` word
- busy  out  1  high whenever not in IDLE
- done  out  1  one-cycle pulse when a run completes

Behaviour:
- Transfer rule, on every interface: a word moves on a posedge when isReady and canReceive are both high.
  - isReady must not depend combinationally on canReceive.
  - Data must hold stable while isReady is high and unaccepted.
- Reset (asynchronous, any state):
  - FSM goes to IDLE; counters are 0; skid buffer is empty.
  - All outputs are low/zero except start_canReceive, which is 1.
- IDLE:
  - start_canReceive=1.
  - On start transfer: latch cmd, nIn and nOut; assert busy next cycle; go to CMD.
- CMD:
  - main_cmd_isReady=1 with the latched command; main_cmd holds 0 in all other states.
  - On transfer, go to IN if nIn≠0, else OUT if nOut≠0, else DONE.
- IN (pass-through, zero latency):
  - main_in = swapBytes64(src_data).
  - main_in_isReady = src_isReady.
  - src_canReceive = main_in_canReceive.
  - Counter decrements per transfer. After the transfer that brings it to 0, go to OUT if nOut≠0, else DONE.
  - src_canReceive=0 and main_in_isReady=0 in every other state.
- OUT:
  - main_out → 2-entry skid buffer → snk. snk_data = swapBytes64 of the stored word.
  - main_out_canReceive = (not full) and (words accepted from `main` < nOut). The block never over-reads `main`.
  - Full throughput: 1 word/cycle when the sink stays ready. Latency from main_out to snk_isReady is 1 cycle.
  - Simultaneous push and pop on a full buffer is disallowed by the canReceive rule. Push and pop with 1 entry keeps occupancy at 1.
  - Leave OUT only after nOut words have been delivered to snk and the skid is empty; then go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy drops in the IDLE cycle.
- Phases are strictly sequential, with no IN/OUT overlap. This matches `main` buffering semantics.
- Counters are CNT_W bits with no wrap. A count of 0 skips the phase.
- Stray main_out_isReady outside OUT is ignored, because canReceive is 0.

Decomposition:
- Shared package/include holds:
  - MainCMD_* constants and MainCMD_SIZE, reused from `main`.
  - swapBytes64 as a shared function.
  - FSM state encodings: IDLE, CMD, IN, OUT, DONE.
- One sub-module: stream_skid2, a generic 2-entry 64-bit valid/ready skid buffer with async reset. It is also reusable on other stream boundaries.

Test Plan:
- Reset mid-IN:
  - Stimulus: start setupTest with nIn=22, nOut=0; assert rst after 5 words.
  - Required: all outputs return to reset values within the same cycle; start_canReceive=1.
  - Required: a fresh run afterwards sends all 22 words.
- Swap check:
  - Stimulus: src word 0x0011223344556677.
  - Required: main_in = 0x7766554433221100.
  - Stimulus: main_out = 0x7766554433221100.
  - Required: snk_data = 0x0011223344556677.
- Throughput:
  - Stimulus: nIn=0, nOut=4; `main` and sink always ready.
  - Required: 4 snk transfers in 4 consecutive cycles, with the first one cycle after the first main_out transfer; done 1 cycle after the last.
- Backpressure:
  - Stimulus: nOut=4; snk_canReceive low for 3 cycles.
  - Required: main_out_canReceive drops after 2 accepted words; no word is lost or duplicated; order is preserved.
- Exact count:
  - Stimulus: nOut=3 with main_out_isReady held high.
  - Required: exactly 3 main_out transfers; main_out_canReceive stays 0 afterwards.
- Zero-length run:
  - Stimulus: start with nIn=0, nOut=0.
  - Required: CMD transfer, then done 1 cycle later; no src/snk activity.
